// File: rtl/cipher_uart_pkg.sv
// Shared types and constants for the cipher block UART transmitter.
// CIPHER_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package cipher_uart_pkg;

  localparam int unsigned BYTES_PER_BLOCK      = 8;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

`ifdef CIPHER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  // Even parity is the plain XOR of the byte; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: bit_done pulses on the last cycle of every bit; load or
// bit_done restarts the count so each bit lasts exactly CLKS_PER_BIT cycles.
module uart_baud_gen
  import cipher_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic bit_done
);

  logic [15:0] cnt;

  assign bit_done = run && (cnt == 16'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || bit_done) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/cipher_uart_tx.sv
// Serialises a 64-bit cipher block as 8 UART frames, MSB byte first, LSB bit first.
// Optional parity bit compiled in with CIPHER_TX_PARITY_EN.
module cipher_uart_tx
  import cipher_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        parity_en,
  input  logic        parity_kind,
  input  logic        blk_valid,
  input  logic [64:1] blk_data,
  output logic        blk_ready,
  output logic        txd,
  output logic        busy,
  output logic        ft
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_BLOCK - 1);

  tx_state_t   state, state_nxt;
  logic [63:0] data_q;
  logic [2:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [7:0]  cur_byte;
  logic        bit_done;
  logic        accept;

  assign blk_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = blk_ready && blk_valid;
  assign cur_byte  = data_q[63:56];

`ifdef CIPHER_TX_PARITY_EN
  logic par_en_q;
  logic par_kind_q;
`else
  logic unused_cfg;
  assign unused_cfg = parity_en | parity_kind;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (CLK),
    .rst_n   (rst_n),
    .load    (accept),
    .run     (busy),
    .bit_done(bit_done)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    txd       = 1'b1;
    ft        = 1'b0;
    case (state)
      IDLE: if (blk_valid) state_nxt = START;
      START: begin
        txd = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        txd = cur_byte[bit_idx];
        if (bit_done && bit_idx == LAST_BIT) begin
`ifdef CIPHER_TX_PARITY_EN
          state_nxt = par_en_q ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef CIPHER_TX_PARITY_EN
      PARITY: begin
        txd = parity_of(cur_byte, par_kind_q);
        if (bit_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (byte_idx == LAST_BYTE) begin
            state_nxt = IDLE;
            ft        = 1'b1;
          end else begin
            state_nxt = START;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The block is shifted a byte at a time so the frame always reads the top byte.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
`ifdef CIPHER_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_kind_q <= 1'b0;
`endif
    end else if (accept) begin
      data_q   <= blk_data;
      byte_idx <= '0;
      bit_idx  <= '0;
`ifdef CIPHER_TX_PARITY_EN
      par_en_q   <= parity_en;
      par_kind_q <= parity_kind;
`endif
    end else if (bit_done) begin
      if (state == DATA) begin
        bit_idx <= bit_idx + 3'd1;
      end else if (state == STOP) begin
        byte_idx <= byte_idx + 3'd1;
        data_q   <= {data_q[55:0], 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Directed self-checking bench for cipher_uart_tx with CLKS_PER_BIT=4.
// Parity checks are selected by CIPHER_TX_PARITY_EN, matching the DUT build.
module tb_cipher_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        parity_en;
  logic        parity_kind;
  logic        blk_valid;
  logic [64:1] blk_data;
  logic        blk_ready;
  logic        txd;
  logic        busy;
  logic        ft;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cipher_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK        (clk),
    .rst_n      (rst_n),
    .parity_en  (parity_en),
    .parity_kind(parity_kind),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_ready  (blk_ready),
    .txd        (txd),
    .busy       (busy),
    .ft         (ft)
  );

  // Expected line level on cycle k (k=1 is the first cycle after acceptance).
  function automatic logic exp_txd(input logic [63:0] blk, input int fb,
                                   input logic pkind, input int k);
    int bp, bidx, pos;
    logic [7:0] b;
    bp   = (k - 1) / CPB;
    bidx = bp / fb;
    pos  = bp % fb;
    b    = blk[63 - 8*bidx -: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (fb == 11 && pos == 9) return (^b) ^ pkind;
    return 1'b1;
  endfunction

  task automatic accept_block(input string name, input logic [63:0] blk,
                              input logic pen, input logic pkind);
    @(negedge clk);
    blk_data    = blk;
    parity_en   = pen;
    parity_kind = pkind;
    blk_valid   = 1'b1;
    checks++;
    if (blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b want 1", name, blk_ready);
    end
    @(posedge clk);
  endtask

  // mode 0: inputs quiet; 1: random input churn; 2: valid held, data switched to alt
  task automatic watch(input string name, input logic [63:0] blk, input int fb,
                       input logic pkind, input int mode, input logic [63:0] alt,
                       input int total, output int ft_cnt, output int ft_at);
    int shown;
    logic e;
    shown  = 0;
    ft_cnt = 0;
    ft_at  = -1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      case (mode)
        0: blk_valid = 1'b0;
        1: begin
          blk_valid   = (k < total - 2) ? 1'($urandom) : 1'b0;
          blk_data    = {$urandom, $urandom};
          parity_en   = 1'($urandom);
          parity_kind = 1'($urandom);
        end
        default: begin
          blk_valid = 1'b1;
          if (k == 10) blk_data = alt;
        end
      endcase
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1 || blk_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_busy: got busy=%b ready=%b want 1/0", name, busy, blk_ready);
        end
      end
      e = exp_txd(blk, fb, pkind, k);
      checks++;
      if (txd !== e) begin
        errors++;
        if (shown < 5) $display("FAIL %s_txd cycle %0d: got %b want %b", name, k, txd, e);
        shown++;
      end
      if (ft === 1'b1) begin
        ft_cnt++;
        ft_at = k;
      end
    end
  endtask

  task automatic check_ft(input string name, input int ft_cnt, input int ft_at, input int want);
    checks++;
    if (ft_cnt !== 1 || ft_at !== want) begin
      errors++;
      $display("FAIL %s_ft: got %0d pulses at cycle %0d want 1 at %0d", name, ft_cnt, ft_at, want);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    blk_valid = 1'b0;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || blk_ready !== 1'b1 || ft !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got txd=%b busy=%b ready=%b ft=%b want 1/0/1/0",
               name, txd, busy, blk_ready, ft);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    parity_en   = 1'b0;
    parity_kind = 1'b0;
    blk_valid   = 1'b0;
    blk_data    = '0;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || blk_ready !== 1'b1 || busy !== 1'b0 || ft !== 1'b0) begin
      errors++;
      $display("FAIL reset: got txd=%b ready=%b busy=%b ft=%b want 1/1/0/0",
               txd, blk_ready, busy, ft);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_no_parity();
    int n, at;
    accept_block("nopar", 64'h0123456789ABCDEF, 1'b0, 1'b0);
    watch("nopar", 64'h0123456789ABCDEF, 10, 1'b0, 0, '0, 320, n, at);
    check_ft("nopar", n, at, 320);
    check_idle("nopar");
  endtask

`ifdef CIPHER_TX_PARITY_EN
  task automatic test_parity();
    int n, at;
    accept_block("par_even", 64'h0123456789ABCDEF, 1'b1, 1'b0);
    watch("par_even", 64'h0123456789ABCDEF, 11, 1'b0, 0, '0, 352, n, at);
    check_ft("par_even", n, at, 352);
    check_idle("par_even");
    accept_block("par_odd", 64'h01F0E1D2C3B4A596, 1'b1, 1'b1);
    watch("par_odd", 64'h01F0E1D2C3B4A596, 11, 1'b1, 0, '0, 352, n, at);
    check_ft("par_odd", n, at, 352);
    check_idle("par_odd");
  endtask
`else
  task automatic test_parity();
    int n, at;
    accept_block("par_ignored", 64'h0123456789ABCDEF, 1'b1, 1'b1);
    watch("par_ignored", 64'h0123456789ABCDEF, 10, 1'b0, 0, '0, 320, n, at);
    check_ft("par_ignored", n, at, 320);
    check_idle("par_ignored");
  endtask
`endif

  task automatic test_busy_changes();
    int n, at;
    accept_block("churn", 64'hA55A_3CC3_F00F_9669, 1'b0, 1'b0);
    watch("churn", 64'hA55A_3CC3_F00F_9669, 10, 1'b0, 1, '0, 320, n, at);
    check_ft("churn", n, at, 320);
    check_idle("churn");
  endtask

  task automatic test_reset_mid();
    int n, at;
    logic bad;
    accept_block("rstmid", 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0);
    repeat (49) begin
      @(negedge clk);
      blk_valid = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || blk_ready !== 1'b1 || busy !== 1'b0 || ft !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got txd=%b ready=%b busy=%b ft=%b want 1/1/0/0",
               txd, blk_ready, busy, ft);
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ft !== 1'b0 || txd !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_hold: got activity=%b want 0", bad);
    end
    rst_n = 1'b1;
    accept_block("rstmid_new", 64'h1122334455667788, 1'b0, 1'b0);
    watch("rstmid_new", 64'h1122334455667788, 10, 1'b0, 0, '0, 320, n, at);
    check_ft("rstmid_new", n, at, 320);
    check_idle("rstmid_new");
  endtask

  task automatic test_back_to_back();
    int n, at;
    accept_block("b2b_a", 64'hC0FFEE00DEADBEEF, 1'b0, 1'b0);
    watch("b2b_a", 64'hC0FFEE00DEADBEEF, 10, 1'b0, 2, 64'h8040201008040201, 320, n, at);
    check_ft("b2b_a", n, at, 320);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || blk_ready !== 1'b1 || txd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: got busy=%b ready=%b txd=%b want 0/1/1", busy, blk_ready, txd);
    end
    @(posedge clk);
    watch("b2b_b", 64'h8040201008040201, 10, 1'b0, 0, '0, 320, n, at);
    check_ft("b2b_b", n, at, 320);
    check_idle("b2b_b");
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_busy_changes();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
